// File: rtl/game_of_life_vga_renderer.sv
// rtl/game_of_life_vga_renderer.sv - VGA raster renderer for the 16x16 Game of Life board
module game_of_life_vga_renderer #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_PX  = 24,
  parameter int X0       = 128,
  parameter int Y0       = 48
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] board_i,
  input  logic [3:0]   row_sel_i,
  input  logic         hl_en_i,
  output logic         vga_hsync_o,
  output logic         vga_vsync_o,
  output logic [3:0]   vga_r_o,
  output logic [3:0]   vga_g_o,
  output logic [3:0]   vga_b_o,
  output logic         frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0]       BX0      = 10'(X0);
  localparam logic [9:0]       BX1      = 10'(X0 + 16 * CELL_PX);
  localparam logic [9:0]       BY0      = 10'(Y0);
  localparam logic [9:0]       BY1      = 10'(Y0 + 16 * CELL_PX);
  localparam logic [5:0]       SUB_MAX  = 6'(CELL_PX - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h_cnt, r_v_cnt;
  logic [5:0]       r_x_sub, r_y_sub;
  logic [3:0]       r_x_cell, r_y_cell;
  logic [255:0]     r_shadow;
  logic [3:0]       r_row_sel;
  logic             r_hl_en;
  logic             r_s1_vis, r_s1_grid, r_s1_hs, r_s1_vs;
  logic [7:0]       r_s1_idx;
  logic [3:0]       r_s1_row;
  logic [11:0]      r_rgb;
  logic             r_hs, r_vs, r_frame_start;

  logic             w_tick, w_h_wrap, w_snap, w_active, w_in_board, w_hs_raw, w_vs_raw;
  logic [9:0]       w_h_next, w_v_next;
  logic [11:0]      w_rgb;

  assign w_tick     = (r_div == DIV_MAX);
  assign w_h_wrap   = (r_h_cnt == H_MAX);
  assign w_h_next   = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
  assign w_v_next   = !w_h_wrap ? r_v_cnt : ((r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1);
  assign w_snap     = w_tick && (r_h_cnt == 10'd0) && (r_v_cnt == V_ACT);
  assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_in_board = (r_h_cnt >= BX0) && (r_h_cnt < BX1) && (r_v_cnt >= BY0) && (r_v_cnt < BY1);
  assign w_hs_raw   = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
  assign w_vs_raw   = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));

  // Pixel clock enable: one tick every PIX_DIV clocks
  always_ff @(posedge clk) begin
    if (!reset_n)    r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Raster counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (w_tick) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  // Cell sub-counters track position inside the board so no divider is needed;
  // they restart whenever the raster is about to enter the board edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x_sub  <= 6'd0;
      r_x_cell <= 4'd0;
      r_y_sub  <= 6'd0;
      r_y_cell <= 4'd0;
    end else if (w_tick) begin
      if (w_h_next == BX0) begin
        r_x_sub  <= 6'd0;
        r_x_cell <= 4'd0;
      end else if (r_x_sub == SUB_MAX) begin
        r_x_sub  <= 6'd0;
        r_x_cell <= r_x_cell + 4'd1;
      end else begin
        r_x_sub  <= r_x_sub + 6'd1;
      end
      if (w_h_wrap) begin
        if (w_v_next == BY0) begin
          r_y_sub  <= 6'd0;
          r_y_cell <= 4'd0;
        end else if (r_y_sub == SUB_MAX) begin
          r_y_sub  <= 6'd0;
          r_y_cell <= r_y_cell + 4'd1;
        end else begin
          r_y_sub  <= r_y_sub + 6'd1;
        end
      end
    end
  end

  // Frame snapshot of board and highlight controls, taken at the start of vertical blanking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shadow      <= '0;
      r_row_sel     <= 4'd0;
      r_hl_en       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap;
      if (w_snap) begin
        r_shadow  <= board_i;
        r_row_sel <= row_sel_i;
        r_hl_en   <= hl_en_i;
      end
    end
  end

  // Stage 1: region, grid flag and board bit index; bit 15 of a row is the leftmost cell
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_vis  <= 1'b0;
      r_s1_grid <= 1'b0;
      r_s1_idx  <= 8'd0;
      r_s1_row  <= 4'd0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
    end else if (w_tick) begin
      r_s1_vis  <= w_active && w_in_board;
      r_s1_grid <= (r_x_sub == 6'd0) || (r_y_sub == 6'd0);
      r_s1_idx  <= {r_y_cell, ~r_x_cell};
      r_s1_row  <= r_y_cell;
      r_s1_hs   <= w_hs_raw;
      r_s1_vs   <= w_vs_raw;
    end
  end

  // Colour priority: outside -> black, grid -> grey, alive -> green, highlighted dead -> blue
  always_comb begin
    w_rgb = 12'h000;
    if (r_s1_vis) begin
      if (r_s1_grid)                              w_rgb = 12'h444;
      else if (r_shadow[r_s1_idx])                w_rgb = 12'h0F0;
      else if (r_hl_en && (r_s1_row == r_row_sel)) w_rgb = 12'h008;
    end
  end

  // Stage 2: registered colour and syncs, aligned with each other
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rgb <= 12'h000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (w_tick) begin
      r_rgb <= w_rgb;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign vga_r_o       = r_rgb[11:8];
  assign vga_g_o       = r_rgb[7:4];
  assign vga_b_o       = r_rgb[3:0];
  assign vga_hsync_o   = r_hs;
  assign vga_vsync_o   = r_vs;
  assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_game_of_life_vga_renderer.sv
// tb/tb_game_of_life_vga_renderer.sv - directed bench for game_of_life_vga_renderer on a scaled raster
module tb_game_of_life_vga_renderer;

  localparam int PD  = 2;
  localparam int HA  = 80, HFP = 2, HS = 4, HBP = 2;
  localparam int VA  = 68, VFP = 2, VS = 2, VBP = 2;
  localparam int CP  = 4,  BX  = 8, BY = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] board_i;
  logic [3:0]   row_sel_i;
  logic         hl_en_i;
  logic         vga_hsync_o, vga_vsync_o, frame_start_o;
  logic [3:0]   vga_r_o, vga_g_o, vga_b_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int base     = 0;
  int hs_fall = 0, hs_per = 0, hs_low = 0;
  int vs_fall = 0, vs_per = 0, vs_low = 0;
  int fs_rise = 0, fs_per = 0, fs_w = 0;
  logic p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0;

  game_of_life_vga_renderer #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CELL_PX(CP), .X0(BX), .Y0(BY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .board_i(board_i), .row_sel_i(row_sel_i), .hl_en_i(hl_en_i),
    .vga_hsync_o(vga_hsync_o), .vga_vsync_o(vga_vsync_o),
    .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge timestamps of syncs and frame_start, sampled mid-cycle
  always @(negedge clk) begin
    if (p_hs && !vga_hsync_o) begin hs_per = cyc - hs_fall; hs_fall = cyc; end
    if (!p_hs && vga_hsync_o) hs_low = cyc - hs_fall;
    if (p_vs && !vga_vsync_o) begin vs_per = cyc - vs_fall; vs_fall = cyc; end
    if (!p_vs && vga_vsync_o) vs_low = cyc - vs_fall;
    if (!p_fs && frame_start_o) begin fs_per = cyc - fs_rise; fs_rise = cyc; end
    if (p_fs && !frame_start_o) fs_w = cyc - fs_rise;
    p_hs = vga_hsync_o;
    p_vs = vga_vsync_o;
    p_fs = frame_start_o;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rgb();
    return 32'({vga_r_o, vga_g_o, vga_b_o});
  endfunction

  // Advance to the negedge at which raster pixel (h,v) of frame f is on the outputs
  task automatic wait_pix(input int f, input int h, input int v);
    int target;
    target = base + (f * FT + v * HT + h + 2) * PD;
    if (cyc > target) check_eq("sched_late", cyc, target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pix(input string tag, input int f, input int h, input int v, input int exp);
    wait_pix(f, h, v);
    check_eq(tag, rgb(), exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    board_i   = '1;
    row_sel_i = 4'd0;
    hl_en_i   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("rst_hs",  32'(vga_hsync_o), 1);
      check_eq("rst_vs",  32'(vga_vsync_o), 1);
      check_eq("rst_rgb", rgb(), 0);
      check_eq("rst_fs",  32'(frame_start_o), 0);
    end
    board_i   = '0;
    board_i[0]  = 1'b1;
    board_i[63] = 1'b1;
    row_sel_i = 4'd3;
    hl_en_i   = 1'b1;
    reset_n   = 1'b1;
    base      = cyc;

    pix("f0_grid", 0, 8, 5, 12'h444);
    pix("f0_dead", 0, 13, 5, 12'h000);

    pix("f1_row0_grid_top", 1, 9, 2, 12'h444);
    pix("f1_left_out",      1, 4, 3, 12'h000);
    pix("f1_grid_left",     1, 8, 3, 12'h444);
    pix("f1_dead_c15",      1, 9, 3, 12'h000);
    pix("f1_grid_x12",      1, 12, 3, 12'h444);
    pix("f1_alive_bit0",    1, 69, 3, 12'h0F0);
    pix("f1_right_out",     1, 72, 3, 12'h000);
    wait_pix(1, 81, 3);
    check_eq("f1_hs_before", 32'(vga_hsync_o), 1);
    pix("f1_hblank",        1, 84, 3, 12'h000);
    check_eq("f1_hs_low", 32'(vga_hsync_o), 0);
    pix("f1_row2_dead",     1, 13, 11, 12'h000);
    pix("f1_row3_grid",     1, 13, 14, 12'h444);
    pix("f1_row3_alive",    1, 9, 15, 12'h0F0);
    pix("f1_row3_hl",       1, 13, 15, 12'h008);

    wait_pix(1, 0, 30);
    board_i   = '1;
    hl_en_i   = 1'b0;
    row_sel_i = 4'd9;
    pix("f1_no_tear",       1, 13, 40, 12'h000);
    wait_pix(1, 10, 69);
    check_eq("f1_vs_before", 32'(vga_vsync_o), 1);
    pix("f1_vblank",        1, 10, 70, 12'h000);
    check_eq("f1_vs_low", 32'(vga_vsync_o), 0);

    pix("f2_alive_new",     2, 13, 3, 12'h0F0);
    pix("f2_row3_alive",    2, 13, 15, 12'h0F0);

    check_eq("hs_period", hs_per, HT * PD);
    check_eq("hs_low",    hs_low, HS * PD);
    check_eq("vs_period", vs_per, FT * PD);
    check_eq("vs_low",    vs_low, VS * HT * PD);
    check_eq("fs_period", fs_per, FT * PD);
    check_eq("fs_width",  fs_w, 1);

    pix("f2_pre_reset",     2, 13, 51, 12'h0F0);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_rgb", rgb(), 0);
    check_eq("mid_rst_hs",  32'(vga_hsync_o), 1);
    check_eq("mid_rst_vs",  32'(vga_vsync_o), 1);
    check_eq("mid_rst_fs",  32'(frame_start_o), 0);
    reset_n = 1'b1;
    base    = cyc;

    pix("post_rst_shadow",  0, 13, 3, 12'h000);
    while (fs_rise <= base && cyc < base + FT * PD * 2) @(negedge clk);
    check_eq("post_rst_fs_delay", fs_rise - base, VA * HT * PD + PD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
